alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle multiply controller that owns the shared ALU's control and operand ports. It computes the low D_WIDTH bits of an unsigned product by iterative shift-and-add, using the single-cycle ALU add path once per multiplier bit. While idle it passes the core's ALU controls through unchanged. While a multiply runs it takes over the ALU and asserts a stall toward the core.

## Interface
Parameters
- D_WIDTH, 32, datapath width; must match the ALU.

Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply; sampled only in IDLE
- multiplicand  in  D_WIDTH  operand A, captured on accepted start
- multiplier  in  D_WIDTH  operand B, captured on accepted start
- busy  out  1  high while in RUN; core stall
- done  out  1  one-cycle pulse: product valid
- product  out  D_WIDTH  low D_WIDTH bits of A*B; held until next accepted start
- core_alusrc  in  1  core ALU operand-2 select
- core_aluctrl  in  3  core ALU opcode
- core_aluop1  in  D_WIDTH  core operand 1
- core_immop  in  D_WIDTH  core immediate operand
- core_regop2  in  D_WIDTH  core register operand
- alusrc  out  1  to ALU
- aluctrl  out  3  to ALU
- aluop1  out  D_WIDTH  to ALU
- immop  out  D_WIDTH  to ALU
- regop2  out  D_WIDTH  to ALU
- aluout  in  D_WIDTH  result from ALU

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - The ALU port mux is transparent: each ALU output equals its core_* counterpart.
  - On start=1: acc<=0, mcand<=multiplicand, mplier<=multiplier, cnt<=0, then go to RUN.
- RUN drives the ALU as follows: alusrc=1, aluctrl=3'b000 (add), aluop1=acc, immop=mcand, regop2=0. The core inputs are ignored.
- RUN, each cycle:
  - If mplier[0]=1, acc<=aluout; otherwise acc holds.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
- RUN exit:
  - Leave for DONE when (mplier>>1)==0 or cnt==D_WIDTH-1. This gives early termination on the highest set bit.
  - On exit, product<=next acc value.
- DONE: done=1 for one cycle; the ALU mux is transparent again; go to IDLE unconditionally.
- Arithmetic:
  - Unsigned, modulo 2^D_WIDTH. Overflow bits are discarded, so the low half is also correct for two's-complement operands.
  - cnt is $clog2(D_WIDTH) bits wide.
- start while in RUN or DONE is ignored and not queued.
- Reset, asynchronous and possibly mid-operation: state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, product=0, busy=0, done=0. Any multiply in flight is abandoned with no done pulse.

## Timing
- Accepted start at edge N (state IDLE).
- RUN occupies cycles N+1 .. N+k, where k = max(1, index of highest set bit of multiplier + 1).
- done is high in cycle N+k+1; product is valid from that cycle on.
- Latency bounds: minimum 2 cycles from start to done (multiplier 0 or 1); maximum D_WIDTH+1.
- A new start is accepted no earlier than the cycle after DONE (back-to-back spacing of k+2 cycles).
- busy is registered: it rises the cycle after start and falls in the DONE cycle.
- The ALU port mux is combinational on state; there is no added latency on the core path while idle.

## Structure
- Shared package alu_pkg:
  - aluctrl encodings ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011; the ALU and this block both import them.
  - State enum mul_state_t {IDLE, RUN, DONE}.
- No sub-module. The ALU is instantiated by the parent, which connects it to this block's ALU-side ports.

## Test plan
- Reset, then start with A=6, B=7: busy for 3 cycles; done in cycle N+4; product=42.
- A=0x1234, B=0: one RUN cycle; done at N+2; product=0.
- A=0xFFFFFFFF, B=0xFFFFFFFF: 32 RUN cycles; done at N+33; product=0x00000001.
- Idle pass-through: core_aluctrl=000, core_alusrc=1, core_aluop1=5, core_immop=7 gives aluout=12 on the ALU outputs in the same cycle. During RUN, changing the core inputs leaves the multiply result unaffected.
- start pulsed again in the 2nd RUN cycle with A=9, B=9 (first multiply A=3, B=0x80): ignored; product=0x180 from the first operands.
- rst_n low mid-RUN of A=5, B=0xFF: all outputs 0, no done pulse. After release, a new start with A=2, B=3 yields 6.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the multiply sequencer state type.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the shared ALU's add path and
// stalls the core while it runs; otherwise the ALU ports pass straight through.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [D_WIDTH-1:0] multiplicand,
   input  logic [D_WIDTH-1:0] multiplier,
   output logic               busy,
   output logic               done,
   output logic [D_WIDTH-1:0] product,
   input  logic               core_alusrc,
   input  logic [2:0]         core_aluctrl,
   input  logic [D_WIDTH-1:0] core_aluop1,
   input  logic [D_WIDTH-1:0] core_immop,
   input  logic [D_WIDTH-1:0] core_regop2,
   output logic               alusrc,
   output logic [2:0]         aluctrl,
   output logic [D_WIDTH-1:0] aluop1,
   output logic [D_WIDTH-1:0] immop,
   output logic [D_WIDTH-1:0] regop2,
   input  logic [D_WIDTH-1:0] aluout
);

   localparam int CNT_W = $clog2(D_WIDTH);

   mul_state_t         state_r;
   mul_state_t         state_next_s;
   logic [D_WIDTH-1:0] acc_r;
   logic [D_WIDTH-1:0] acc_next_s;
   logic [D_WIDTH-1:0] mcand_r;
   logic [D_WIDTH-1:0] mplier_r;
   logic [D_WIDTH-1:0] product_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               busy_r;
   logic               done_r;
   logic               last_s;

   // Next state, accumulator update and RUN exit detection.
   always_comb begin
      state_next_s = state_r;
      acc_next_s   = acc_r;
      last_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) state_next_s = RUN;
            else       state_next_s = IDLE;
         end
         RUN: begin
            if (mplier_r[0]) acc_next_s = aluout;
            else             acc_next_s = acc_r;
            // Stop once no higher multiplier bits remain, or after the last bit.
            last_s = ((mplier_r >> 1) == '0) || (cnt_r == CNT_W'(D_WIDTH - 1));
            if (last_s) state_next_s = DONE;
            else        state_next_s = RUN;
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // ALU port mux: sequencer owns the ALU only while running.
   always_comb begin
      alusrc  = core_alusrc;
      aluctrl = core_aluctrl;
      aluop1  = core_aluop1;
      immop   = core_immop;
      regop2  = core_regop2;
      if (state_r == RUN) begin
         alusrc  = 1'b1;
         aluctrl = ALU_ADD;
         aluop1  = acc_r;
         immop   = mcand_r;
         regop2  = '0;
      end else begin
         alusrc  = core_alusrc;
         aluctrl = core_aluctrl;
      end
   end

   // State register and multiply datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         acc_r     <= '0;
         mcand_r   <= '0;
         mplier_r  <= '0;
         cnt_r     <= '0;
         product_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == RUN);
         done_r  <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  acc_r    <= '0;
                  mcand_r  <= multiplicand;
                  mplier_r <= multiplier;
                  cnt_r    <= '0;
               end
            end
            RUN: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CNT_W'(1);
               if (last_s) product_r <= acc_next_s;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and randomized bench for alu_mul_seq with a behavioural ALU and product model.
module tb_alu_mul_seq;
   import alu_pkg::*;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] multiplicand;
   logic [DW-1:0] multiplier;
   logic          busy;
   logic          done;
   logic [DW-1:0] product;
   logic          core_alusrc;
   logic [2:0]    core_aluctrl;
   logic [DW-1:0] core_aluop1;
   logic [DW-1:0] core_immop;
   logic [DW-1:0] core_regop2;
   logic          alusrc;
   logic [2:0]    aluctrl;
   logic [DW-1:0] aluop1;
   logic [DW-1:0] immop;
   logic [DW-1:0] regop2;
   logic [DW-1:0] aluout;

   int checks = 0;
   int errors = 0;

   alu_mul_seq #(.D_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .busy(busy), .done(done), .product(product),
      .core_alusrc(core_alusrc), .core_aluctrl(core_aluctrl),
      .core_aluop1(core_aluop1), .core_immop(core_immop), .core_regop2(core_regop2),
      .alusrc(alusrc), .aluctrl(aluctrl), .aluop1(aluop1),
      .immop(immop), .regop2(regop2), .aluout(aluout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-cycle ALU that the parent would normally instantiate.
   logic [DW-1:0] op2;
   always_comb begin
      op2 = alusrc ? immop : regop2;
      case (aluctrl)
         ALU_ADD: aluout = aluop1 + op2;
         ALU_SUB: aluout = aluop1 - op2;
         ALU_AND: aluout = aluop1 & op2;
         ALU_OR:  aluout = aluop1 | op2;
         default: aluout = '0;
      endcase
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: RUN length is the position of the highest set multiplier bit, at least 1.
   function automatic int ref_k(input logic [DW-1:0] b);
      int k = 1;
      for (int i = 0; i < DW; i++) if (b[i]) k = i + 1;
      return k;
   endfunction

   task automatic randomize_core();
      core_alusrc  = 1'($urandom);
      core_aluctrl = 3'($urandom_range(0, 3));
      core_aluop1  = $urandom;
      core_immop   = $urandom;
      core_regop2  = $urandom;
   endtask

   // One multiply; optionally re-pulses start in the second RUN cycle with other operands.
   task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit inject, input string tag);
      logic [DW-1:0] exp_p;
      int k;
      int cyc;
      exp_p = a * b;
      k = ref_k(b);
      @(negedge clk);
      start = 1'b1; multiplicand = a; multiplier = b;
      @(posedge clk); #1;
      start = 1'b0;
      multiplicand = $urandom; multiplier = $urandom;
      cyc = 1;
      while (done !== 1'b1 && cyc <= DW + 4) begin
         check({tag, " busy"}, {31'd0, busy}, 32'd1);
         check({tag, " run aluctrl"}, {29'd0, aluctrl}, {29'd0, ALU_ADD});
         if (inject && cyc == 2) begin
            start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
         end else begin
            start = 1'b0;
         end
         randomize_core();
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, " latency"}, cyc, k + 1);
      check({tag, " done"}, {31'd0, done}, 32'd1);
      check({tag, " busy low at done"}, {31'd0, busy}, 32'd0);
      check({tag, " product"}, product, exp_p);
      @(posedge clk); #1;
      check({tag, " done pulse"}, {31'd0, done}, 32'd0);
      check({tag, " product held"}, product, exp_p);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
      core_alusrc = 1'b0; core_aluctrl = 3'b000;
      core_aluop1 = '0; core_immop = '0; core_regop2 = '0;
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset product", product, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_mul(32'd6, 32'd7, 1'b0, "6x7");
      run_mul(32'h1234, 32'd0, 1'b0, "bzero");
      run_mul(32'd77, 32'd1, 1'b0, "bone");
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "allones");

      // Idle pass-through of core controls.
      @(negedge clk);
      core_alusrc = 1'b1; core_aluctrl = ALU_ADD;
      core_aluop1 = 32'd5; core_immop = 32'd7; core_regop2 = 32'd100;
      #1;
      check("pass aluout", aluout, 32'd12);
      check("pass regop2", regop2, 32'd100);
      core_alusrc = 1'b0; core_aluctrl = ALU_SUB;
      #1;
      check("pass sub", aluout, 32'hFFFF_FFA1);
      check("pass aluctrl", {29'd0, aluctrl}, {29'd0, ALU_SUB});

      run_mul(32'd3, 32'h80, 1'b1, "ignored start");

      // Asynchronous reset mid-run abandons the multiply.
      @(negedge clk);
      start = 1'b1; multiplicand = 32'd5; multiplier = 32'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst done", {31'd0, done}, 32'd0);
      check("midrst product", product, 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 2) rst_n = 1'b1;
         check("no done after reset", {31'd0, done}, 32'd0);
      end
      check("product after abandon", product, 32'd0);
      run_mul(32'd2, 32'd3, 1'b0, "after reset");

      for (int i = 0; i < 12; i++) begin
         logic [DW-1:0] a;
         logic [DW-1:0] b;
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_mul(a, b, 1'b0, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
